mdc_seq: RTL and testbench
==========================

MDC_SEQ -- requirements
Module: mdc_seq

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits.
REQ-002 Parameter DEPTH, default 4: operand-pair FIFO entries; a power of two and at least 2.
REQ-003 Parameter TIMEOUT, default 1024: maximum cycles to wait for core completion.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_i  in  1  reset; synchronous, active-high.
REQ-006 x_i  in  WIDTH  operand X of the incoming pair.
REQ-007 y_i  in  WIDTH  operand Y of the incoming pair.
REQ-008 valid_i  in  1  incoming pair valid.
REQ-009 ready_o  out  1  FIFO can accept a pair.
REQ-010 mdc_x_o  out  WIDTH  operand X driven to the GCD core.
REQ-011 mdc_y_o  out  WIDTH  operand Y driven to the GCD core.
REQ-012 mdc_enb_o  out  1  one-cycle start pulse to the core's enb_i.
REQ-013 mdc_done_i  in  1  core result-valid, connected to the core's enb_o.
REQ-014 mdc_res_i  in  WIDTH  core result, sampled only when mdc_done_i=1.
REQ-015 res_o  out  WIDTH  GCD result.
REQ-016 valid_o  out  1  res_o valid.
REQ-017 ready_i  in  1  downstream accepts res_o.
REQ-018 count_o  out  $clog2(DEPTH+1)  FIFO occupancy.
REQ-019 err_o  out  1  sticky timeout flag.

Function
REQ-020 The FIFO shall push on valid_i&&ready_o and shall drive ready_o = (count_o<DEPTH), computed from registered occupancy only.
REQ-021 The FSM shall have four states: IDLE, CHECK, LAUNCH and WAIT.
REQ-022 IDLE shall go to CHECK when the FIFO is non-empty and valid_o=0, popping the head pair into the mdc_x_o/mdc_y_o registers in that same cycle.
REQ-023 In CHECK, if either operand is 0, the block shall load res_o with the other operand (0 if both are 0), set valid_o=1 and return to IDLE; mdc_enb_o shall not be asserted.
REQ-024 In CHECK, if both operands are nonzero, the FSM shall go to LAUNCH.
REQ-025 LAUNCH shall assert mdc_enb_o for exactly one cycle and then go to WAIT.
REQ-026 mdc_x_o and mdc_y_o shall be stable from CHECK through the end of WAIT.
REQ-027 In WAIT, mdc_done_i=1 shall capture mdc_res_i into res_o, set valid_o=1 and return the FSM to IDLE.
REQ-028 In WAIT, a cycle counter shall start at 0 on entry; on reaching TIMEOUT without mdc_done_i, err_o shall be set, the pair shall be dropped, and the FSM shall return to IDLE.
REQ-029 valid_o shall clear on valid_o&&ready_i; res_o shall hold while valid_o=1&&ready_i=0.
REQ-030 Push and pop in the same cycle shall leave count_o unchanged; read and write pointers shall wrap modulo DEPTH.
REQ-031 A push while full shall be ignored, because ready_o=0 in that case.
REQ-032 mdc_done_i outside WAIT shall be ignored.
REQ-033 The pair-to-result order shall be strictly FIFO, with at most one pair in flight.

Reset
REQ-034 While rst_i=1 at a clock edge, the block shall set FSM=IDLE, FIFO pointers and count_o=0, ready_o=1, valid_o=0, res_o=0, mdc_enb_o=0, mdc_x_o=mdc_y_o=0, err_o=0 and the timeout counter to 0.
REQ-035 Reset asserted in any state, including mid-WAIT, shall discard all buffered and in-flight pairs; the next operation after reset shall start only from a new push.
REQ-036 err_o shall clear only on reset.

Verification
REQ-037 Reset scenario: after rst_i, ready_o=1, valid_o=0, count_o=0, err_o=0, mdc_enb_o=0.
REQ-038 Single pair: push (12,18) against a core model -> mdc_enb_o pulses exactly once with mdc_x_o=12 and mdc_y_o=18, then res_o=6 with valid_o=1.
REQ-039 Zero bypass: push (0,9) -> res_o=9 and valid_o=1 within 2 cycles of the pop, with no mdc_enb_o pulse; push (0,0) -> res_o=0.
REQ-040 Backpressure: ready_i=0 and 6 pairs pushed back-to-back -> the first pair is launched and its result held, pairs 2-5 are buffered with count_o=4, ready_o=0 while the 6th pair is held; raising ready_i drains the results in order.
REQ-041 Timeout: core model never asserts done -> err_o=1 exactly TIMEOUT cycles after entering WAIT, the FSM returns to IDLE, and the next pair proceeds normally.
REQ-042 Mid-WAIT reset: assert rst_i during WAIT with 2 pairs queued -> all outputs return to their reset values, and a later mdc_done_i produces no valid_o.

Source files
------------

// File: rtl/mdc_seq.sv
// -----------------------------------------------------------------------------
// mdc_seq
// Sequencer that feeds operand pairs from a small FIFO to an external GCD
// ("MDC") core, one pair at a time, and presents the results in pair order.
// Pairs with a zero operand are resolved locally without starting the core.
// A core that does not answer within TIMEOUT cycles is abandoned, the pair is
// dropped and a sticky error flag is raised.
//
// Parameters
//   WIDTH    operand / result width
//   DEPTH    operand-pair FIFO entries (power of two, >= 2)
//   TIMEOUT  cycles to wait for core completion before giving up
//
// Ports
//   clk          rising-edge clock
//   rst_i        synchronous active-high reset
//   x_i, y_i     incoming operand pair
//   valid_i      incoming pair valid
//   ready_o      FIFO can accept a pair (from registered occupancy)
//   mdc_x_o      operand X to the core, stable from CHECK through WAIT
//   mdc_y_o      operand Y to the core, stable from CHECK through WAIT
//   mdc_enb_o    one-cycle start pulse to the core
//   mdc_done_i   core result valid (only honoured in WAIT)
//   mdc_res_i    core result
//   res_o        GCD result
//   valid_o      res_o valid, cleared on valid_o && ready_i
//   ready_i      downstream accepts res_o
//   count_o      FIFO occupancy
//   err_o        sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module mdc_seq #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                         clk,
   input  logic                         rst_i,
   input  logic [WIDTH-1:0]             x_i,
   input  logic [WIDTH-1:0]             y_i,
   input  logic                         valid_i,
   output logic                         ready_o,
   output logic [WIDTH-1:0]             mdc_x_o,
   output logic [WIDTH-1:0]             mdc_y_o,
   output logic                         mdc_enb_o,
   input  logic                         mdc_done_i,
   input  logic [WIDTH-1:0]             mdc_res_i,
   output logic [WIDTH-1:0]             res_o,
   output logic                         valid_o,
   input  logic                         ready_i,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         err_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam int unsigned TW = $clog2(TIMEOUT+1);

   localparam logic [CW-1:0] C_FULL  = CW'(DEPTH);
   localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT-1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_CHECK  = 2'd1;
   localparam logic [1:0] ST_LAUNCH = 2'd2;
   localparam logic [1:0] ST_WAIT   = 2'd3;

   // ---------------------------------------------------------------- storage
   logic [WIDTH-1:0] r_mem_x [DEPTH];
   logic [WIDTH-1:0] r_mem_y [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_mx;
   logic [WIDTH-1:0] r_my;
   logic             r_enb;
   logic [WIDTH-1:0] r_res;
   logic             r_valid;
   logic [TW-1:0]    r_tcnt;
   logic             r_err;

   logic             w_ready;
   logic             w_push;
   logic             w_pop;
   logic             w_zero_op;

   // ready depends on registered occupancy only, never on a same-cycle pop
   assign w_ready   = (r_count < C_FULL);
   assign w_push    = valid_i && w_ready;
   // a new pair is only taken once the previous result has been handed off
   assign w_pop     = (r_state == ST_IDLE) && (r_count != '0) && !r_valid;
   assign w_zero_op = (r_mx == '0) || (r_my == '0);

   // ------------------------------------------------------------ FIFO data
   // Payload storage needs no reset: occupancy alone qualifies its contents.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_x[r_wptr] <= x_i;
         r_mem_y[r_wptr] <= y_i;
      end
   end

   // ------------------------------------------------------ FIFO pointers
   // DEPTH is a power of two, so natural pointer overflow gives modulo-DEPTH.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // --------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_mx    <= '0;
         r_my    <= '0;
         r_enb   <= 1'b0;
         r_res   <= '0;
         r_valid <= 1'b0;
         r_tcnt  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_enb <= 1'b0;

         if (r_valid && ready_i) begin
            r_valid <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_mx    <= r_mem_x[r_rptr];
                  r_my    <= r_mem_y[r_rptr];
                  r_state <= ST_CHECK;
               end
            end

            ST_CHECK: begin
               if (w_zero_op) begin
                  // at least one operand is zero, so OR yields the other one
                  r_res   <= r_mx | r_my;
                  r_valid <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  // registered pulse: high exactly during the LAUNCH cycle
                  r_enb   <= 1'b1;
                  r_state <= ST_LAUNCH;
               end
            end

            ST_LAUNCH: begin
               r_tcnt  <= '0;
               r_state <= ST_WAIT;
            end

            ST_WAIT: begin
               if (mdc_done_i) begin
                  r_res   <= mdc_res_i;
                  r_valid <= 1'b1;
                  r_state <= ST_IDLE;
               end else if (r_tcnt == T_LAST) begin
                  // TIMEOUT cycles spent in WAIT: drop the pair
                  r_err   <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_tcnt <= r_tcnt + TW'(1);
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------ outputs
   assign ready_o   = w_ready;
   assign count_o   = r_count;
   assign mdc_x_o   = r_mx;
   assign mdc_y_o   = r_my;
   assign mdc_enb_o = r_enb;
   assign res_o     = r_res;
   assign valid_o   = r_valid;
   assign err_o     = r_err;

endmodule

// File: tb/tb_mdc_seq.sv
// -----------------------------------------------------------------------------
// tb_mdc_seq
// Self-checking bench for mdc_seq. A behavioural GCD core answers start
// pulses after a random or fixed latency; a pair queue plus Euclid's
// algorithm predicts every launch and every delivered result.
// -----------------------------------------------------------------------------
module tb_mdc_seq;

   localparam int W  = 8;
   localparam int D  = 4;
   localparam int TO = 40;

   logic         clk = 1'b0;
   logic         rst_i;
   logic [W-1:0] x_i, y_i;
   logic         valid_i;
   logic         ready_o;
   logic [W-1:0] mdc_x_o, mdc_y_o;
   logic         mdc_enb_o;
   logic         mdc_done_i;
   logic [W-1:0] mdc_res_i;
   logic [W-1:0] res_o;
   logic         valid_o;
   logic         ready_i;
   logic [2:0]   count_o;
   logic         err_o;

   mdc_seq #(
      .WIDTH   (W),
      .DEPTH   (D),
      .TIMEOUT (TO)
   ) dut (
      .clk        (clk),
      .rst_i      (rst_i),
      .x_i        (x_i),
      .y_i        (y_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .mdc_x_o    (mdc_x_o),
      .mdc_y_o    (mdc_y_o),
      .mdc_enb_o  (mdc_enb_o),
      .mdc_done_i (mdc_done_i),
      .mdc_res_i  (mdc_res_i),
      .res_o      (res_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .count_o    (count_o),
      .err_o      (err_o)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int unsigned ref_gcd(input int unsigned a_in, input int unsigned b_in);
      int unsigned a = a_in;
      int unsigned b = b_in;
      int unsigned t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   typedef struct {
      logic [W-1:0] x;
      logic [W-1:0] y;
   } pair_t;

   pair_t        pairq[$];

   // core model / monitor state
   bit           core_hang  = 1'b0;
   bit           core_busy  = 1'b0;
   bit           core_stale = 1'b0;
   bit           stray_req  = 1'b0;
   bit           prev_enb   = 1'b0;
   bit           rand_rdy   = 1'b0;
   int           core_lat   = 0;
   int           fixed_lat  = -1;
   int           enb_count  = 0;
   logic [W-1:0] core_x, core_y;

   // Behavioural core plus scoreboard, all sampled on the falling edge.
   always @(negedge clk) begin
      pair_t p;
      mdc_done_i = 1'b0;
      if (stray_req) begin
         mdc_done_i = 1'b1;
         mdc_res_i  = 8'($urandom);
         stray_req  = 1'b0;
      end else if (core_busy) begin
         if (core_lat == 0) begin
            mdc_done_i = 1'b1;
            mdc_res_i  = 8'(ref_gcd(core_x, core_y));
            core_busy  = 1'b0;
            if (!core_stale) begin
               check("x_stable", mdc_x_o, core_x);
               check("y_stable", mdc_y_o, core_y);
            end
            core_stale = 1'b0;
         end else begin
            core_lat--;
         end
      end

      if (mdc_enb_o) begin
         enb_count++;
         check("enb_one_cycle", prev_enb, 0);
         if (pairq.size() == 0) begin
            check("launch_unexpected", mdc_enb_o, 0);
         end else begin
            check("launch_x", mdc_x_o, pairq[0].x);
            check("launch_y", mdc_y_o, pairq[0].y);
         end
         if (!core_hang) begin
            core_busy = 1'b1;
            core_x    = mdc_x_o;
            core_y    = mdc_y_o;
            core_lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 5));
         end
      end
      prev_enb = mdc_enb_o;

      if (!rst_i && valid_o && ready_i) begin
         if (pairq.size() == 0) begin
            check("res_unexpected", valid_o, 0);
         end else begin
            p = pairq.pop_front();
            check("res", res_o, ref_gcd(p.x, p.y));
         end
      end

      if (!rst_i && valid_i && ready_o) begin
         pairq.push_back('{x_i, y_i});
      end
   end

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         ready_i = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [W-1:0] x, input logic [W-1:0] y);
      int n = 0;
      x_i     = x;
      y_i     = y;
      valid_i = 1'b1;
      while (!ready_o && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) check("push_timeout", ready_o, 1);
      tick();
      valid_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((pairq.size() != 0 || valid_o || count_o != 0) && n < 3000) begin
         tick();
         n++;
      end
      if (n >= 3000) check("drain_timeout", pairq.size(), 0);
      tick();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"}, ready_o, 1);
      check({tag, "_valid"}, valid_o, 0);
      check({tag, "_count"}, count_o, 0);
      check({tag, "_err"},   err_o,   0);
      check({tag, "_enb"},   mdc_enb_o, 0);
      check({tag, "_res"},   res_o,   0);
      check({tag, "_mx"},    mdc_x_o, 0);
      check({tag, "_my"},    mdc_y_o, 0);
   endtask

   initial begin
      int    e0, n, k;
      bit    saw_valid;
      logic [W-1:0] rx, ry;

      rst_i = 1'b1; valid_i = 1'b0; x_i = '0; y_i = '0;
      ready_i = 1'b1; mdc_done_i = 1'b0; mdc_res_i = '0;
      repeat (3) tick();
      check_reset_vals("reset");
      rst_i = 1'b0;
      tick();

      // done pulse while idle must be ignored
      stray_req = 1'b1;
      repeat (3) tick();
      check("stray_done_valid", valid_o, 0);

      // single pair through the core
      e0 = enb_count;
      push(8'd12, 8'd18);
      n = 0;
      while (!valid_o && n < 50) begin tick(); n++; end
      check("single_res", res_o, 6);
      drain();
      check("single_enb", enb_count - e0, 1);

      // zero bypass
      e0 = enb_count;
      push(8'd0, 8'd9);
      n = 0;
      while (!valid_o && n < 10) begin tick(); n++; end
      check("bypass_latency", n, 2);
      check("bypass_res", res_o, 9);
      drain();
      push(8'd0, 8'd0);
      drain();
      push(8'd7, 8'd0);
      drain();
      check("bypass_enb", enb_count - e0, 0);

      // randomized traffic with random downstream backpressure
      rand_rdy = 1'b1;
      for (int i = 0; i < 30; i++) begin
         rx = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         ry = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         repeat ($urandom_range(0, 2)) tick();
         push(rx, ry);
      end
      drain();
      rand_rdy = 1'b0;
      tick();
      ready_i = 1'b1;
      tick();

      // backpressure: first result held, FIFO fills, sixth pair waits
      ready_i   = 1'b0;
      fixed_lat = 2;
      e0        = enb_count;
      push(8'd12, 8'd18);
      push(8'd35, 8'd49);
      push(8'd100, 8'd75);
      push(8'd81, 8'd27);
      push(8'd64, 8'd48);
      x_i = 8'd17; y_i = 8'd51; valid_i = 1'b1;
      n = 0;
      while (!valid_o && n < 50) begin tick(); n++; end
      repeat (3) tick();
      check("bp_count", count_o, 4);
      check("bp_ready", ready_o, 0);
      check("bp_valid", valid_o, 1);
      check("bp_res",   res_o,   6);
      check("bp_enb",   enb_count - e0, 1);
      repeat (2) tick();
      check("bp_hold_res", res_o, 6);
      ready_i = 1'b1;
      n = 0;
      while (!ready_o && n < 100) begin tick(); n++; end
      tick();
      valid_i = 1'b0;
      drain();
      check("bp_enb_total", enb_count - e0, 6);
      fixed_lat = -1;

      // timeout: core never answers
      core_hang = 1'b1;
      push(8'd15, 8'd25);
      n = 0;
      do begin @(negedge clk); n++; end while (!mdc_enb_o && n < 50);
      k = 0;
      do begin @(negedge clk); k++; end while (!err_o && k < 3 * TO);
      check("timeout_cycles", k, TO + 1);
      check("timeout_valid", valid_o, 0);
      tick();
      void'(pairq.pop_front());
      core_hang = 1'b0;
      check("timeout_count", count_o, 0);
      e0 = enb_count;
      push(8'd20, 8'd30);
      drain();
      check("after_timeout_enb", enb_count - e0, 1);
      check("err_sticky", err_o, 1);

      // reset while waiting on the core with two pairs queued
      fixed_lat = 20;
      e0 = enb_count;
      push(8'd12, 8'd18);
      push(8'd35, 8'd49);
      push(8'd100, 8'd75);
      n = 0;
      while (enb_count == e0 && n < 50) begin tick(); n++; end
      repeat (3) tick();
      check("midwait_count", count_o, 2);
      core_stale = 1'b1;
      rst_i = 1'b1;
      tick();
      check_reset_vals("midwait_reset");
      rst_i = 1'b0;
      pairq.delete();
      e0 = enb_count;
      saw_valid = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         saw_valid |= valid_o;
      end
      check("stale_done_valid", saw_valid, 0);
      check("stale_enb", enb_count - e0, 0);
      check("stale_count", count_o, 0);
      fixed_lat = -1;
      push(8'd9, 8'd6);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
